cost_server: RTL

COST_SERVER -- requirements
Module: cost_server

---
 rtl/cost_server_if.sv | 29 ++
 rtl/cost_server.sv | 89 ++++++++
 2 files changed

// File: rtl/cost_server_if.sv
// Bus between the cost table server, its table source and the job-assignment engine.
// The master side drives load data, engine indices and engine results; the slave is the server.
interface cost_server_if;
   logic        ld_valid;
   logic        ld_ready;
   logic [6:0]  ld_data;
   logic [2:0]  w;
   logic [2:0]  j;
   logic [6:0]  cost;
   logic        jam_rst;
   logic        valid;
   logic [9:0]  min_cost;
   logic [3:0]  match_count;
   logic [9:0]  res_mincost;
   logic [3:0]  res_match;
   logic [15:0] run_cycles;
   logic        done;
   logic        timeout;

   modport master (
      output ld_valid, ld_data, w, j, valid, min_cost, match_count,
      input  ld_ready, cost, jam_rst, res_mincost, res_match, run_cycles, done, timeout
   );

   modport slave (
      input  ld_valid, ld_data, w, j, valid, min_cost, match_count,
      output ld_ready, cost, jam_rst, res_mincost, res_match, run_cycles, done, timeout
   );
endinterface

// File: rtl/cost_server.sv
// Cost table server: loads a 64x7 cost table, arms the engine, serves costs combinationally
// while it runs, then captures the engine result or declares a timeout.
module cost_server #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input logic          clk,
   input logic          rst_n,
   cost_server_if.slave bus
);
   typedef enum logic [2:0] {S_LOAD, S_ARM, S_RUN, S_DONE, S_TOUT} state_t;

   localparam logic [15:0] TOUT_AT = 16'(TIMEOUT_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic        rst_ok;
   logic        load_beat;
   logic [5:0]  addr;
   logic [6:0]  table_mem [64];
   logic [9:0]  res_mincost_q;
   logic [3:0]  res_match_q;
   logic [15:0] run_cycles_q;

   // Reset release is retimed by one flop, so the first state action lands on the
   // second rising edge after deassertion; ld_valid in that gap cycle is not taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_ok <= 1'b0;
      else        rst_ok <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_LOAD;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (rst_ok) begin
         case (state)
            S_LOAD:  if (bus.ld_valid && addr == 6'd63) state_next = S_ARM;
            S_ARM:   state_next = S_RUN;
            S_RUN: begin
               if (bus.valid)                     state_next = S_DONE;
               else if (run_cycles_q == TOUT_AT)  state_next = S_TOUT;
            end
            default: state_next = state;
         endcase
      end
   end

   assign load_beat = rst_ok && (state == S_LOAD) && bus.ld_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 64; i++) table_mem[i] <= '0;
      end else if (load_beat) begin
         table_mem[addr] <= bus.ld_data;
      end
   end

   // The address wraps naturally from 63 back to 0 as the last entry is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) addr <= '0;
      else if (load_beat) addr <= addr + 6'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cycles_q  <= '0;
         res_mincost_q <= '0;
         res_match_q   <= '0;
      end else if (rst_ok && state == S_RUN) begin
         if (run_cycles_q != 16'hFFFF) run_cycles_q <= run_cycles_q + 16'd1;
         if (bus.valid) begin
            res_mincost_q <= bus.min_cost;
            res_match_q   <= bus.match_count;
         end
      end
   end

   assign bus.ld_ready    = (state == S_LOAD);
   assign bus.jam_rst     = (state == S_LOAD) || (state == S_ARM);
   assign bus.cost        = (state == S_RUN) ? table_mem[{bus.w, bus.j}] : 7'd0;
   assign bus.res_mincost = res_mincost_q;
   assign bus.res_match   = res_match_q;
   assign bus.run_cycles  = run_cycles_q;
   assign bus.done        = (state == S_DONE);
   assign bus.timeout     = (state == S_TOUT);
endmodule
